// File: rtl/mips_cpu_bus_run_pkg.sv
// Shared types and constants for the MIPS CPU bus run controller.
// The run-state enum and the protocol error codes live here. Both the
// top level and the protocol checker use them.
package mips_cpu_bus_run_pkg;

   // Run controller states
   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      WAIT_ACT,
      RUN,
      DONE,
      TOUT
   } run_state_e;

   // Protocol error codes reported on proto_err_code
   localparam logic [2:0] NONE     = 3'd0;
   localparam logic [2:0] RW       = 3'd1;
   localparam logic [2:0] BE0      = 3'd2;
   localparam logic [2:0] MISALIGN = 3'd3;
   localparam logic [2:0] UNSTABLE = 3'd4;

   // True for the states in which the CPU is out of reset and being monitored
   function automatic logic is_monitoring(input run_state_e st);
      return (st == WAIT_ACT) || (st == RUN);
   endfunction

endpackage

// File: rtl/mips_cpu_bus_proto_chk.sv
// Avalon master-side protocol checker for the MIPS CPU bus.
// It flags the first violation seen while en_i is high and keeps that code
// until clr_i or reset. It remembers the previous cycle's request so that a
// stalled transfer can be checked for stability.
module mips_cpu_bus_proto_chk
   import mips_cpu_bus_run_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        bus_read_i,
   input  logic        bus_write_i,
   input  logic        bus_waitrequest_i,
   input  logic [31:0] bus_address_i,
   input  logic [3:0]  bus_byteenable_i,
   output logic        err_o,
   output logic        err_next_o,
   output logic [2:0]  code_o
);

   logic        req;
   logic        stall_q, stall_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic        err_q, err_d;
   logic [2:0]  code_q, code_d;
   logic [2:0]  code_now;

   assign req = bus_read_i | bus_write_i;

   // Classify this cycle's violation (lowest code wins) and latch the first one
   always_comb begin
      code_now = NONE;
      if (en_i) begin
         if (bus_read_i && bus_write_i) begin
            code_now = RW;
         end else if (req && (bus_byteenable_i == 4'b0000)) begin
            code_now = BE0;
         end else if (req && (bus_address_i[1:0] != 2'b00)) begin
            code_now = MISALIGN;
         end else if (stall_q && (!req || (bus_address_i != addr_q) ||
                                  (bus_byteenable_i != be_q))) begin
            // A stalled request must be held unchanged until it is accepted
            code_now = UNSTABLE;
         end
      end

      err_d  = err_q;
      code_d = code_q;
      if (clr_i) begin
         err_d  = 1'b0;
         code_d = NONE;
      end else if (!err_q && (code_now != NONE)) begin
         err_d  = 1'b1;
         code_d = code_now;
      end

      stall_d = en_i && req && bus_waitrequest_i && !clr_i;
      addr_d  = bus_address_i;
      be_d    = bus_byteenable_i;
   end

   // Previous-cycle request snapshot and sticky error registers
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= 1'b0;
         addr_q  <= 32'h0;
         be_q    <= 4'h0;
         err_q   <= 1'b0;
         code_q  <= NONE;
      end else begin
         stall_q <= stall_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   assign err_o      = err_q;
   assign err_next_o = err_d;
   assign code_o     = code_q;

endmodule

// File: rtl/mips_cpu_bus_run_ctrl.sv
// Run controller and bus monitor for the Avalon-bus MIPS CPU.
// On start it holds the CPU in reset, waits for the CPU to go active, then
// counts cycles and accepted transfers until the CPU halts or the budget
// runs out. At halt it captures v0 and forms a pass/fail verdict.
// Optional bus protocol checking: define MIPS_CPU_BUS_RUN_CTRL_PROTO_CHECK_EN.
module mips_cpu_bus_run_ctrl
   import mips_cpu_bus_run_pkg::*;
#(
   parameter int unsigned RESET_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 10000,
   parameter int unsigned CNT_W          = 32,
   parameter logic [31:0] EXPECTED_V0    = 32'h0,
   parameter bit          CHECK_V0       = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             cpu_reset,
   input  logic             cpu_active,
   input  logic [31:0]      cpu_register_v0,
   input  logic             bus_read,
   input  logic             bus_write,
   input  logic             bus_waitrequest,
   input  logic [31:0]      bus_address,
   input  logic [3:0]       bus_byteenable,
   output logic             busy,
   output logic             done,
   output logic             timed_out,
   output logic             pass,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] read_count,
   output logic [CNT_W-1:0] write_count,
   output logic [31:0]      v0_captured,
   output logic             proto_err,
   output logic [2:0]       proto_err_code
);

   localparam int unsigned      HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   run_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              tout_q, tout_d;
   logic              pass_q, pass_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [31:0]       v0_q, v0_d;

   logic              start_acc;
   logic              monitoring;
   logic              at_timeout;
   logic              perr;
   logic              perr_next;
   logic [2:0]        perr_code;

   assign monitoring = is_monitoring(state_q);
   assign start_acc  = start && !busy_q;
   assign at_timeout = (cycle_q == TO_LAST);

`ifdef MIPS_CPU_BUS_RUN_CTRL_PROTO_CHECK_EN
   mips_cpu_bus_proto_chk u_proto_chk (
      .clk               (clk),
      .reset             (reset),
      .clr_i             (start_acc),
      .en_i              (monitoring),
      .bus_read_i        (bus_read),
      .bus_write_i       (bus_write),
      .bus_waitrequest_i (bus_waitrequest),
      .bus_address_i     (bus_address),
      .bus_byteenable_i  (bus_byteenable),
      .err_o             (perr),
      .err_next_o        (perr_next),
      .code_o            (perr_code)
   );
`else
   logic unused_bus;
   assign unused_bus = ^{bus_address, bus_byteenable};
   assign perr       = 1'b0;
   assign perr_next  = 1'b0;
   assign perr_code  = NONE;
`endif

   // Next-state, counter and verdict logic
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
      tout_d      = tout_q;
      cycle_d     = cycle_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      v0_d        = v0_q;

      case (state_q)
         IDLE: begin
            cpu_reset_d = 1'b1;
         end
         HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d     = WAIT_ACT;
               cpu_reset_d = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         WAIT_ACT: begin
            if (at_timeout) begin
               state_d = TOUT;
               tout_d  = 1'b1;
            end else if (cpu_active) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Halt beats timeout when both happen in the same cycle
            if (!cpu_active) begin
               state_d = DONE;
               done_d  = 1'b1;
               v0_d    = cpu_register_v0;
            end else if (at_timeout) begin
               state_d = TOUT;
               tout_d  = 1'b1;
            end
         end
         DONE, TOUT: begin
            cpu_reset_d = 1'b0;
         end
         default: begin
            state_d     = IDLE;
            cpu_reset_d = 1'b1;
         end
      endcase

      if (monitoring) begin
         if (cycle_q != CNT_MAX) begin
            cycle_d = cycle_q + 1'b1;
         end
         if (bus_read && !bus_waitrequest && (rd_cnt_q != CNT_MAX)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
         if (bus_write && !bus_waitrequest && (wr_cnt_q != CNT_MAX)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end

      // A new run restarts from a clean slate with the CPU held in reset
      if (start_acc) begin
         state_d     = HOLD;
         hold_cnt_d  = '0;
         cpu_reset_d = 1'b1;
         done_d      = 1'b0;
         tout_d      = 1'b0;
         cycle_d     = '0;
         rd_cnt_d    = '0;
         wr_cnt_d    = '0;
         v0_d        = 32'h0;
      end

      busy_d = (state_d == HOLD) || (state_d == WAIT_ACT) || (state_d == RUN);
      pass_d = done_d && (!CHECK_V0 || (v0_d == EXPECTED_V0)) && !perr_next;
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         hold_cnt_q  <= '0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tout_q      <= 1'b0;
         pass_q      <= 1'b0;
         cycle_q     <= '0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         v0_q        <= 32'h0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         tout_q      <= tout_d;
         pass_q      <= pass_d;
         cycle_q     <= cycle_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         v0_q        <= v0_d;
      end
   end

   assign cpu_reset      = cpu_reset_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign timed_out      = tout_q;
   assign pass           = pass_q;
   assign cycle_count    = cycle_q;
   assign read_count     = rd_cnt_q;
   assign write_count    = wr_cnt_q;
   assign v0_captured    = v0_q;
   assign proto_err      = perr;
   assign proto_err_code = perr_code;

endmodule

// File: tb/tb_mips_cpu_bus_run_ctrl.sv
// Directed bench for mips_cpu_bus_run_ctrl.
// Two instances share all stimulus. dut_a checks v0 against 5 and
// dut_b passes on any clean halt. Both use a 50-cycle budget.
// Protocol expectations follow MIPS_CPU_BUS_RUN_CTRL_PROTO_CHECK_EN.
module tb_mips_cpu_bus_run_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        cpu_active;
   logic [31:0] cpu_register_v0;
   logic        bus_read;
   logic        bus_write;
   logic        bus_waitrequest;
   logic [31:0] bus_address;
   logic [3:0]  bus_byteenable;

   logic        a_cpu_reset, a_busy, a_done, a_timed_out, a_pass, a_proto_err;
   logic [31:0] a_cycle_count, a_read_count, a_write_count, a_v0_captured;
   logic [2:0]  a_proto_err_code;
   logic        b_cpu_reset, b_busy, b_done, b_timed_out, b_pass, b_proto_err;
   logic [31:0] b_cycle_count, b_read_count, b_write_count, b_v0_captured;
   logic [2:0]  b_proto_err_code;

   int checks = 0;
   int errors = 0;
   int hi;

   always #5 clk = ~clk;

   mips_cpu_bus_run_ctrl #(
      .RESET_CYCLES(2), .TIMEOUT_CYCLES(50), .CNT_W(32),
      .EXPECTED_V0(32'h5), .CHECK_V0(1'b1)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start), .cpu_reset(a_cpu_reset),
      .cpu_active(cpu_active), .cpu_register_v0(cpu_register_v0),
      .bus_read(bus_read), .bus_write(bus_write), .bus_waitrequest(bus_waitrequest),
      .bus_address(bus_address), .bus_byteenable(bus_byteenable),
      .busy(a_busy), .done(a_done), .timed_out(a_timed_out), .pass(a_pass),
      .cycle_count(a_cycle_count), .read_count(a_read_count),
      .write_count(a_write_count), .v0_captured(a_v0_captured),
      .proto_err(a_proto_err), .proto_err_code(a_proto_err_code)
   );

   mips_cpu_bus_run_ctrl #(
      .RESET_CYCLES(2), .TIMEOUT_CYCLES(50), .CNT_W(32),
      .EXPECTED_V0(32'h5), .CHECK_V0(1'b0)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start), .cpu_reset(b_cpu_reset),
      .cpu_active(cpu_active), .cpu_register_v0(cpu_register_v0),
      .bus_read(bus_read), .bus_write(bus_write), .bus_waitrequest(bus_waitrequest),
      .bus_address(bus_address), .bus_byteenable(bus_byteenable),
      .busy(b_busy), .done(b_done), .timed_out(b_timed_out), .pass(b_pass),
      .cycle_count(b_cycle_count), .read_count(b_read_count),
      .write_count(b_write_count), .v0_captured(b_v0_captured),
      .proto_err(b_proto_err), .proto_err_code(b_proto_err_code)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: pulse start, then count negedges with cpu_reset high
   task automatic start_and_hold(output int n_hi);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_hi = 0;
      while (a_cpu_reset && n_hi < 20) begin
         n_hi++;
         @(negedge clk);
      end
   endtask

   // Called at a negedge after cpu_reset fell: CPU active for n edges, then halt with v0
   task automatic cpu_run(input int n, input logic [31:0] v0);
      cpu_active = 1'b1;
      repeat (n) @(posedge clk);
      @(negedge clk);
      cpu_active      = 1'b0;
      cpu_register_v0 = v0;
      @(negedge clk);
      cpu_register_v0 = 32'hDEAD_BEEF;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; cpu_active = 1'b0;
      cpu_register_v0 = 32'hDEAD_BEEF;
      bus_read = 1'b0; bus_write = 1'b0; bus_waitrequest = 1'b0;
      bus_address = 32'h0; bus_byteenable = 4'hF;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_cpu_reset", {31'b0, a_cpu_reset}, 32'd1);
      check("rst_cpu_reset_b", {31'b0, b_cpu_reset}, 32'd1);
      check("rst_busy", {31'b0, a_busy}, 32'd0);
      check("rst_flags", {28'b0, a_done, a_timed_out, a_pass, a_proto_err}, 32'd0);
      check("rst_counts", a_cycle_count | a_read_count | a_write_count | a_v0_captured, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Run 1: clean halt with v0=5 after 40 active cycles
      start_and_hold(hi);
      check("r1_reset_hold", hi, 32'd2);
      cpu_run(40, 32'h5);
      check("r1_done", {31'b0, a_done}, 32'd1);
      check("r1_pass", {31'b0, a_pass}, 32'd1);
      check("r1_v0", a_v0_captured, 32'h5);
      check("r1_cycles", a_cycle_count, 32'd41);
      check("r1_cycles_b", b_cycle_count, 32'd41);
      check("r1_busy", {31'b0, a_busy}, 32'd0);
      check("r1_cpu_reset", {31'b0, a_cpu_reset}, 32'd0);
      @(negedge clk);
      check("r1_v0_held", a_v0_captured, 32'h5);

      // Run 2: restart from DONE, halt with wrong v0
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("r2_clear_cycles", a_cycle_count, 32'd0);
      check("r2_clear_done", {31'b0, a_done}, 32'd0);
      hi = 0;
      while (a_cpu_reset && hi < 20) begin
         hi++;
         @(negedge clk);
      end
      check("r2_reset_hold", hi, 32'd2);
      cpu_run(40, 32'h6);
      check("r2_done", {31'b0, a_done}, 32'd1);
      check("r2_pass", {31'b0, a_pass}, 32'd0);
      check("r2_done_b", {31'b0, b_done}, 32'd1);
      check("r2_pass_nocheck", {31'b0, b_pass}, 32'd1);
      check("r2_v0_b", b_v0_captured, 32'h6);

      // Run 3: CPU never halts, 50-cycle budget
      start_and_hold(hi);
      cpu_active = 1'b1;
      repeat (49) @(negedge clk);
      check("r3_pre_tout", {30'b0, a_timed_out, a_busy}, 32'd1);
      check("r3_pre_cycles", a_cycle_count, 32'd49);
      @(negedge clk);
      check("r3_tout", {31'b0, a_timed_out}, 32'd1);
      check("r3_tout_b", {31'b0, b_timed_out}, 32'd1);
      check("r3_busy", {30'b0, a_busy, b_busy}, 32'd0);
      check("r3_pass", {30'b0, a_pass, b_pass}, 32'd0);
      check("r3_done", {31'b0, a_done}, 32'd0);
      check("r3_cycles", a_cycle_count, 32'd50);
      check("r3_cpu_reset", {31'b0, a_cpu_reset}, 32'd0);
      cpu_active = 1'b0;
      @(negedge clk);

      // Run 4: bus transfers, plus a start pulse that must be ignored
      start_and_hold(hi);
      cpu_active = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("r4_start_ignored", {30'b0, a_cpu_reset, a_busy}, 32'd1);
      check("r4_cycles", a_cycle_count, 32'd1);
      for (int i = 0; i < 3; i++) begin
         bus_read = 1'b1; bus_address = 32'h100 + 32'(4 * i); bus_waitrequest = 1'b1;
         repeat (2) @(negedge clk);
         bus_waitrequest = 1'b0;
         @(negedge clk);
         bus_read = 1'b0;
         @(negedge clk);
      end
      for (int i = 0; i < 2; i++) begin
         bus_write = 1'b1; bus_address = 32'h200 + 32'(4 * i);
         @(negedge clk);
         bus_write = 1'b0;
         @(negedge clk);
      end
      check("r4_reads", a_read_count, 32'd3);
      check("r4_writes", a_write_count, 32'd2);
      check("r4_reads_b", b_read_count, 32'd3);
      check("r4_writes_b", b_write_count, 32'd2);
      cpu_run(1, 32'h5);
      check("r4_pass", {31'b0, a_pass}, 32'd1);
      check("r4_proto", {28'b0, a_proto_err, a_proto_err_code}, 32'd0);

      // Run 5: reset mid-run, then a fresh run counts from zero
      start_and_hold(hi);
      cpu_active = 1'b1;
      repeat (3) @(negedge clk);
      bus_write = 1'b1;
      @(negedge clk);
      bus_write = 1'b0;
      check("r5_write_before", a_write_count, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; cpu_active = 1'b0;
      check("r5_cpu_reset", {31'b0, a_cpu_reset}, 32'd1);
      check("r5_flags", {27'b0, a_busy, a_done, a_timed_out, a_pass, a_proto_err}, 32'd0);
      check("r5_counts", a_cycle_count | a_write_count | a_read_count | a_v0_captured, 32'd0);
      @(negedge clk);
      start_and_hold(hi);
      check("r5_reset_hold", hi, 32'd2);
      check("r5_restart_cycles", a_cycle_count, 32'd0);
      cpu_active = 1'b1;
      @(negedge clk);
      bus_write = 1'b1;
      @(negedge clk);
      bus_write = 1'b0;
      check("r5_restart_writes", a_write_count, 32'd1);
      cpu_run(2, 32'h5);
      check("r5_done", {31'b0, a_done}, 32'd1);

      // Run 6: misaligned read, then read+write together, then correct halt
      start_and_hold(hi);
      cpu_active = 1'b1;
      bus_read = 1'b1; bus_address = 32'h1003;
      @(negedge clk);
      bus_read = 1'b0; bus_address = 32'h0;
      @(negedge clk);
`ifdef MIPS_CPU_BUS_RUN_CTRL_PROTO_CHECK_EN
      check("r6_perr", {31'b0, a_proto_err}, 32'd1);
      check("r6_code", {29'b0, a_proto_err_code}, 32'd3);
`else
      check("r6_perr", {31'b0, a_proto_err}, 32'd0);
      check("r6_code", {29'b0, a_proto_err_code}, 32'd0);
`endif
      bus_read = 1'b1; bus_write = 1'b1;
      @(negedge clk);
      bus_read = 1'b0; bus_write = 1'b0;
      @(negedge clk);
      cpu_run(1, 32'h5);
      check("r6_done", {31'b0, a_done}, 32'd1);
`ifdef MIPS_CPU_BUS_RUN_CTRL_PROTO_CHECK_EN
      check("r6_code_kept", {29'b0, a_proto_err_code}, 32'd3);
      check("r6_perr_b", {31'b0, b_proto_err}, 32'd1);
      check("r6_pass", {30'b0, a_pass, b_pass}, 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("r6_perr_cleared", {28'b0, a_proto_err, a_proto_err_code}, 32'd0);
`else
      check("r6_code_kept", {28'b0, b_proto_err, b_proto_err_code}, 32'd0);
      check("r6_pass", {30'b0, a_pass, b_pass}, 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
